// File: rtl/serial_addsub_pkg.sv
// Shared types for the bit-serial adder/subtractor: FSM state encoding and a width helper.
package serial_addsub_pkg;

  // Encoding 2'd3 is unused and falls back to idle on the next edge.
  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StShift = 2'd1,
    StDone  = 2'd2
  } state_e;

  // Bit-counter width for a given operand width.
  function automatic int unsigned cnt_width(input int unsigned width);
    return $clog2(width) + 1;
  endfunction

endpackage

// File: rtl/full_adder_cell.sv
// Single-bit combinational full adder; the serial datapath reuses it once per bit.
module full_adder_cell (
  input  logic a_i,
  input  logic b_i,
  input  logic cin_i,
  output logic s_o,
  output logic cout_o
);

  always_comb begin
    s_o    = a_i ^ b_i ^ cin_i;
    cout_o = (a_i & b_i) | (a_i & cin_i) | (b_i & cin_i);
  end

endmodule

// File: rtl/serial_addsub.sv
// Bit-serial adder/subtractor: one bit per clock, LSB first, through a registered-carry
// full-adder cell. Result, carry-out and signed overflow are held until the next op finishes.
module serial_addsub
  import serial_addsub_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             sub_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             ready_o,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] sum_o,
  output logic             cout_o,
  output logic             overflow_o
);

  localparam int unsigned CNT_W = cnt_width(WIDTH);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] a_sr_q, a_sr_d;
  logic [WIDTH-1:0] b_sr_q, b_sr_d;
  logic [WIDTH-1:0] res_sr_q, res_sr_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;

  logic fa_s, fa_c;
  logic accept;
  logic last_bit;

  // The result LSB slot is overwritten by the final shift and never read back.
  logic unused_res_lsb;
  assign unused_res_lsb = res_sr_q[0];

  full_adder_cell u_fa (
    .a_i    (a_sr_q[0]),
    .b_i    (b_sr_q[0]),
    .cin_i  (carry_q),
    .s_o    (fa_s),
    .cout_o (fa_c)
  );

  always_comb begin
    ready_o  = (state_q == StIdle) || (state_q == StDone);
    busy_o   = (state_q == StShift);
    done_o   = (state_q == StDone);
    accept   = start_i && ready_o;
    last_bit = (state_q == StShift) && (cnt_q == CNT_W'(WIDTH - 1));
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:  if (start_i) state_d = StShift;
      StShift: if (last_bit) state_d = StDone;
      StDone:  state_d = start_i ? StShift : StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    cnt_d    = cnt_q;
    a_sr_d   = a_sr_q;
    b_sr_d   = b_sr_q;
    res_sr_d = res_sr_q;
    carry_d  = carry_q;
    sum_d    = sum_q;
    cout_d   = cout_q;
    ovf_d    = ovf_q;

    if (accept) begin
      // Subtraction is a + ~b + 1: the +1 enters as the initial carry.
      a_sr_d  = a_i;
      b_sr_d  = sub_i ? ~b_i : b_i;
      carry_d = sub_i;
      cnt_d   = '0;
    end else if (state_q == StShift) begin
      a_sr_d   = a_sr_q >> 1;
      b_sr_d   = b_sr_q >> 1;
      res_sr_d = {fa_s, res_sr_q[WIDTH-1:1]};
      carry_d  = fa_c;
      cnt_d    = cnt_q + CNT_W'(1);
      if (last_bit) begin
        // carry_q here is the carry into the MSB.
        sum_d  = {fa_s, res_sr_q[WIDTH-1:1]};
        cout_d = fa_c;
        ovf_d  = carry_q ^ fa_c;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      a_sr_q   <= '0;
      b_sr_q   <= '0;
      res_sr_q <= '0;
      carry_q  <= 1'b0;
      sum_q    <= '0;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      a_sr_q   <= a_sr_d;
      b_sr_q   <= b_sr_d;
      res_sr_q <= res_sr_d;
      carry_q  <= carry_d;
      sum_q    <= sum_d;
      cout_q   <= cout_d;
      ovf_q    <= ovf_d;
    end
  end

  assign sum_o      = sum_q;
  assign cout_o     = cout_q;
  assign overflow_o = ovf_q;

endmodule

// File: tb/tb_serial_addsub.sv
// Self-checking bench for serial_addsub at widths 4, 8 and 16 against an arithmetic model.
module tb_serial_addsub;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  logic        start4, sub4, ready4, busy4, done4, cout4, ovf4;
  logic [3:0]  a4, b4, sum4;
  logic        start8, sub8, ready8, busy8, done8, cout8, ovf8;
  logic [7:0]  a8, b8, sum8;
  logic        start16, sub16, ready16, busy16, done16, cout16, ovf16;
  logic [15:0] a16, b16, sum16;

  int passed = 0;
  int total  = 0;

  serial_addsub #(.WIDTH(4)) u_dut4 (
    .clk_i(clk), .rst_i(rst), .start_i(start4), .sub_i(sub4), .a_i(a4), .b_i(b4),
    .ready_o(ready4), .busy_o(busy4), .done_o(done4), .sum_o(sum4), .cout_o(cout4),
    .overflow_o(ovf4)
  );

  serial_addsub #(.WIDTH(8)) u_dut8 (
    .clk_i(clk), .rst_i(rst), .start_i(start8), .sub_i(sub8), .a_i(a8), .b_i(b8),
    .ready_o(ready8), .busy_o(busy8), .done_o(done8), .sum_o(sum8), .cout_o(cout8),
    .overflow_o(ovf8)
  );

  serial_addsub #(.WIDTH(16)) u_dut16 (
    .clk_i(clk), .rst_i(rst), .start_i(start16), .sub_i(sub16), .a_i(a16), .b_i(b16),
    .ready_o(ready16), .busy_o(busy16), .done_o(done16), .sum_o(sum16), .cout_o(cout16),
    .overflow_o(ovf16)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: {overflow, cout, sum zero-extended to 16 bits} from plain integer arithmetic.
  function automatic logic [17:0] ref_model(input int w, input logic [15:0] av,
                                            input logic [15:0] bv, input logic sv);
    longint m, ua, ub, sa, sb, r, sr;
    logic   c, ov;
    m  = longint'(1) << w;
    ua = longint'(av) & (m - 1);
    ub = longint'(bv) & (m - 1);
    sa = (ua >= m / 2) ? ua - m : ua;
    sb = (ub >= m / 2) ? ub - m : ub;
    if (!sv) begin
      r  = ua + ub;
      c  = (r >= m);
      sr = sa + sb;
    end else begin
      r  = ua - ub;
      c  = (ua >= ub);
      sr = sa - sb;
    end
    ov = (sr < -(m / 2)) || (sr > (m / 2 - 1));
    return {ov, c, 16'(r & (m - 1))};
  endfunction

  function automatic logic done_of(input int w);
    case (w)
      4:       return done4;
      8:       return done8;
      default: return done16;
    endcase
  endfunction

  function automatic logic [17:0] res_of(input int w);
    case (w)
      4:       return {ovf4, cout4, 12'd0, sum4};
      8:       return {ovf8, cout8, 8'd0, sum8};
      default: return {ovf16, cout16, sum16};
    endcase
  endfunction

  task automatic launch(input int w, input logic [15:0] av, input logic [15:0] bv,
                        input logic sv);
    case (w)
      4:       begin a4 = av[3:0]; b4 = bv[3:0]; sub4 = sv; start4 = 1'b1; end
      8:       begin a8 = av[7:0]; b8 = bv[7:0]; sub8 = sv; start8 = 1'b1; end
      default: begin a16 = av; b16 = bv; sub16 = sv; start16 = 1'b1; end
    endcase
    tick();
    start4  = 1'b0;
    start8  = 1'b0;
    start16 = 1'b0;
  endtask

  // Counts edges after the accept edge until done is seen; -1 if the bound expires.
  task automatic wait_done(input int w, input bit scramble, output int lat);
    lat = -1;
    for (int k = 1; k <= w + 4; k++) begin
      if (scramble) begin
        case (w)
          4:       begin a4 = 4'($urandom); b4 = 4'($urandom); sub4 = 1'($urandom); end
          8:       begin a8 = 8'($urandom); b8 = 8'($urandom); sub8 = 1'($urandom); end
          default: begin a16 = 16'($urandom); b16 = 16'($urandom); sub16 = 1'($urandom); end
        endcase
      end
      tick();
      if (done_of(w)) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    total++; if (ready8 !== 1'b1) $display("FAIL reset.ready got %b want 1", ready8);
    else passed++;
    total++; if (busy8 !== 1'b0) $display("FAIL reset.busy got %b want 0", busy8);
    else passed++;
    total++; if (done8 !== 1'b0) $display("FAIL reset.done got %b want 0", done8);
    else passed++;
    total++; if (sum8 !== 8'h00) $display("FAIL reset.sum got %h want 00", sum8);
    else passed++;
    total++; if (cout8 !== 1'b0) $display("FAIL reset.cout got %b want 0", cout8);
    else passed++;
    total++; if (ovf8 !== 1'b0) $display("FAIL reset.overflow got %b want 0", ovf8);
    else passed++;
    rst = 1'b0;
    tick();
  endtask

  task automatic test_directed();
    logic [7:0] ta[4] = '{8'h3C, 8'hFF, 8'h10, 8'h80};
    logic [7:0] tb[4] = '{8'h55, 8'h01, 8'h20, 8'h01};
    logic       ts[4] = '{1'b0, 1'b0, 1'b1, 1'b1};
    logic [7:0] es[4] = '{8'h91, 8'h00, 8'hF0, 8'h7F};
    logic       ec[4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    logic       eo[4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    int lat;
    for (int i = 0; i < 4; i++) begin
      launch(8, {8'd0, ta[i]}, {8'd0, tb[i]}, ts[i]);
      wait_done(8, 1'b0, lat);
      total++; if (lat != 8) $display("FAIL directed%0d.latency got %0d want 8", i, lat);
      else passed++;
      total++; if (sum8 !== es[i]) $display("FAIL directed%0d.sum got %h want %h", i, sum8, es[i]);
      else passed++;
      total++; if (cout8 !== ec[i]) $display("FAIL directed%0d.cout got %b want %b", i, cout8, ec[i]);
      else passed++;
      total++; if (ovf8 !== eo[i]) $display("FAIL directed%0d.overflow got %b want %b", i, ovf8, eo[i]);
      else passed++;
      tick();
    end
  endtask

  task automatic test_ignore_start();
    logic [17:0] exp;
    int lat;
    exp = ref_model(8, 16'h0012, 16'h0034, 1'b0);
    launch(8, 16'h0012, 16'h0034, 1'b0);
    total++; if ({busy8, ready8} !== 2'b10) $display("FAIL shift.busy_ready got %b want 10", {busy8, ready8});
    else passed++;
    tick();
    tick();
    a8 = 8'hAA; b8 = 8'h77; sub8 = 1'b1; start8 = 1'b1;
    tick();
    start8 = 1'b0;
    wait_done(8, 1'b0, lat);
    total++; if (lat != 5) $display("FAIL ignore.latency got %0d want 5", lat);
    else passed++;
    total++; if (res_of(8) !== exp) $display("FAIL ignore.result got %h want %h", res_of(8), exp);
    else passed++;
    tick();
    total++; if ({done8, ready8, busy8} !== 3'b010) $display("FAIL ignore.no_queue got %b want 010", {done8, ready8, busy8});
    else passed++;
  endtask

  task automatic test_back_to_back();
    logic [15:0] av, bv, av2, bv2;
    logic sv, sv2;
    logic [17:0] exp1, exp2;
    int lat;
    av = 16'($urandom); bv = 16'($urandom); sv = 1'($urandom);
    exp1 = ref_model(8, av, bv, sv);
    launch(8, av, bv, sv);
    wait_done(8, 1'b0, lat);
    for (int i = 0; i < 3; i++) begin
      total++; if (res_of(8) !== exp1) $display("FAIL b2b%0d.first got %h want %h", i, res_of(8), exp1);
      else passed++;
      av2 = 16'($urandom); bv2 = 16'($urandom); sv2 = 1'($urandom);
      exp2 = ref_model(8, av2, bv2, sv2);
      launch(8, av2, bv2, sv2);
      total++; if (busy8 !== 1'b1 || res_of(8) !== exp1)
        $display("FAIL b2b%0d.hold got busy=%b res=%h want busy=1 res=%h", i, busy8, res_of(8), exp1);
      else passed++;
      wait_done(8, 1'b1, lat);
      total++; if (lat != 8) $display("FAIL b2b%0d.latency got %0d want 8", i, lat);
      else passed++;
      exp1 = exp2;
    end
    total++; if (res_of(8) !== exp1) $display("FAIL b2b.last got %h want %h", res_of(8), exp1);
    else passed++;
    tick();
  endtask

  task automatic test_reset_mid();
    logic [17:0] exp;
    bit seen;
    int lat;
    launch(8, 16'h00C3, 16'h005A, 1'b0);
    for (int i = 0; i < 4; i++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    total++; if ({ready8, busy8, done8, cout8, ovf8, sum8} !== {5'b10000, 8'h00})
      $display("FAIL midreset.outputs got %b want %b", {ready8, busy8, done8, cout8, ovf8, sum8}, {5'b10000, 8'h00});
    else passed++;
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (done8) seen = 1'b1;
    end
    total++; if (seen) $display("FAIL midreset.no_done got done pulse want none");
    else passed++;
    exp = ref_model(8, 16'h0071, 16'h00E4, 1'b1);
    launch(8, 16'h0071, 16'h00E4, 1'b1);
    wait_done(8, 1'b0, lat);
    total++; if (lat != 8 || res_of(8) !== exp)
      $display("FAIL midreset.next_op got lat=%0d res=%h want lat=8 res=%h", lat, res_of(8), exp);
    else passed++;
    tick();
  endtask

  task automatic test_sweep4();
    logic [17:0] exp;
    int lat;
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        for (int s = 0; s < 2; s++) begin
          exp = ref_model(4, 16'(a), 16'(b), 1'(s));
          launch(4, 16'(a), 16'(b), 1'(s));
          wait_done(4, 1'b1, lat);
          total++; if (lat != 4 || res_of(4) !== exp)
            $display("FAIL sweep4 a=%0d b=%0d sub=%0d got lat=%0d res=%h want lat=4 res=%h",
                     a, b, s, lat, res_of(4), exp);
          else passed++;
        end
      end
    end
    tick();
  endtask

  task automatic test_random(input int w, input int n);
    logic [15:0] av, bv;
    logic sv;
    logic [17:0] exp;
    int lat;
    for (int i = 0; i < n; i++) begin
      av = 16'($urandom); bv = 16'($urandom); sv = 1'($urandom);
      if (i % 7 == 0) bv = av;
      exp = ref_model(w, av, bv, sv);
      launch(w, av, bv, sv);
      wait_done(w, 1'b1, lat);
      total++; if (lat != w || res_of(w) !== exp)
        $display("FAIL random%0d a=%h b=%h sub=%b got lat=%0d res=%h want lat=%0d res=%h",
                 w, av, bv, sv, lat, res_of(w), w, exp);
      else passed++;
      if ($urandom_range(0, 3) == 0) tick();
    end
    tick();
  endtask

  initial begin
    rst = 1'b1;
    start4 = 1'b0; sub4 = 1'b0; a4 = '0; b4 = '0;
    start8 = 1'b0; sub8 = 1'b0; a8 = '0; b8 = '0;
    start16 = 1'b0; sub16 = 1'b0; a16 = '0; b16 = '0;
    test_reset();
    test_directed();
    test_ignore_start();
    test_back_to_back();
    test_reset_mid();
    test_sweep4();
    test_random(8, 200);
    test_random(16, 1000);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
